// File: rtl/writeback_unit.sv
// Register-file write master: arbitrates ALU results against buffered load
// results, and tracks the destination registers of loads that are still in flight.
module writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  input  logic                     issue_ld,
  input  logic [REG_AW-1:0]        issue_rd,
  output logic [(1<<REG_AW)-1:0]   busy,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_a3,
  output logic [XLEN-1:0]          rf_wd3
);

  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NREG = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  wb_entry_t         fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rf_we_q;
  logic [REG_AW-1:0] rf_a3_q;
  logic [XLEN-1:0]   rf_wd3_q;

  logic      full, empty, alu_xfer, mem_xfer;
  logic      push, pop, sel_valid, sel_is_load, commit_we;
  wb_entry_t head, alu_entry, mem_entry, sel;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign alu_ready = ~full;
  assign mem_ready = ~full;
  assign alu_xfer  = alu_valid & ~full;
  assign mem_xfer  = mem_valid & ~full;
  assign head      = fifo_q[rd_ptr_q];
  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign mem_entry = '{rd: mem_rd, data: mem_data};

  // Write-port arbitration: a full FIFO drains first, then ALU, then buffered loads, then bypass
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    sel_valid   = 1'b0;
    sel_is_load = 1'b0;
    sel         = head;
    if (full) begin
      sel_valid   = 1'b1;
      sel_is_load = 1'b1;
      pop         = 1'b1;
    end else if (alu_xfer) begin
      sel_valid = 1'b1;
      sel       = alu_entry;
      push      = mem_xfer;
    end else if (!empty) begin
      sel_valid   = 1'b1;
      sel_is_load = 1'b1;
      pop         = 1'b1;
      push        = mem_xfer;
    end else if (mem_xfer) begin
      sel_valid   = 1'b1;
      sel_is_load = 1'b1;
      sel         = mem_entry;
    end
  end

  assign commit_we = sel_valid & (sel.rd != '0);

  always_comb begin
    wr_ptr_d = push ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? PW'(rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = CW'(count_q + CW'(push) - CW'(pop));
  end

  // Pending-load mask: a new issue overrides a commit to the same register
  always_comb begin
    busy_d = busy_q;
    if (sel_valid && sel_is_load) busy_d[sel.rd] = 1'b0;
    if (issue_ld) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      rf_we_q  <= commit_we;
      if (commit_we) begin
        rf_a3_q  <= sel.rd;
        rf_wd3_q <= sel.data;
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_entry;
  end

  assign busy   = busy_q;
  assign rf_we  = rf_we_q;
  assign rf_a3  = rf_a3_q;
  assign rf_wd3 = rf_wd3_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed scenarios for writeback_unit; expected rf writes are queued in
// commit order and matched by a monitor whenever rf_we is seen high.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_ld;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q [$];

  writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_ld(issue_ld), .issue_rd(issue_rd), .busy(busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Every rf write must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", {32'd0, rf_wd3}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check_eq("wr_a3_wd3", 64'({rf_a3, rf_wd3}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_ld = 1'b0; issue_rd = '0;

    // Reset state
    step();
    check_eq("rst_we",   64'(rf_we), 64'd0);
    check_eq("rst_a3",   64'(rf_a3), 64'd0);
    check_eq("rst_wd3",  64'(rf_wd3), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rdy",  64'({alu_ready, mem_ready}), 64'd3);
    rst_n = 1'b1;
    step();

    // 1: single ALU write, one cycle wide
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    push_exp(5'd5, 32'hDEADBEEF);
    step();
    alu_valid = 1'b0;
    check_eq("alu_we",  64'(rf_we), 64'd1);
    check_eq("alu_a3",  64'(rf_a3), 64'd5);
    check_eq("alu_wd3", 64'(rf_wd3), 64'hDEADBEEF);
    step();
    check_eq("alu_we_drop", 64'(rf_we), 64'd0);

    // 2: issued load sets busy, bypass commit clears it
    issue_ld = 1'b1; issue_rd = 5'd7;
    step();
    issue_ld = 1'b0;
    check_eq("busy7_set", 64'(busy), 64'h80);
    step(); step();
    check_eq("busy7_hold", 64'(busy), 64'h80);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h12;
    push_exp(5'd7, 32'h12);
    step();
    mem_valid = 1'b0;
    check_eq("byp_we",   64'(rf_we), 64'd1);
    check_eq("byp_a3",   64'(rf_a3), 64'd7);
    check_eq("busy7_clr", 64'(busy), 64'd0);
    step();

    // 3: ALU busy every cycle fills FIFO; loads then drain in order
    issue_ld = 1'b1; issue_rd = 5'd8;
    step();
    issue_rd = 5'd9;
    step();
    issue_ld = 1'b0;
    check_eq("busy89", 64'(busy), 64'h300);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h88;
    push_exp(5'd1, 32'h100);
    step();
    alu_rd = 5'd2; alu_data = 32'h200;
    mem_rd = 5'd9; mem_data = 32'h99;
    push_exp(5'd2, 32'h200);
    step();
    mem_valid = 1'b0;
    alu_rd = 5'd3; alu_data = 32'h300;
    check_eq("full_rdy", 64'({alu_ready, mem_ready}), 64'd0);
    push_exp(5'd8, 32'h88);
    step();
    check_eq("head_a3",   64'(rf_a3), 64'd8);
    check_eq("busy8_clr", 64'(busy), 64'h200);
    check_eq("drain_rdy", 64'({alu_ready, mem_ready}), 64'd3);
    push_exp(5'd3, 32'h300);
    step();
    alu_valid = 1'b0;
    check_eq("alu3_a3", 64'(rf_a3), 64'd3);
    check_eq("busy9_hold", 64'(busy), 64'h200);
    push_exp(5'd9, 32'h99);
    step();
    check_eq("ld9_a3",  64'(rf_a3), 64'd9);
    check_eq("ld9_wd3", 64'(rf_wd3), 64'h99);
    check_eq("busy9_clr", 64'(busy), 64'd0);
    step();

    // 4: ALU and load together with empty FIFO
    issue_ld = 1'b1; issue_rd = 5'd10;
    step();
    issue_ld = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hAA;
    push_exp(5'd4, 32'h44);
    push_exp(5'd10, 32'hAA);
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check_eq("n1_a3", 64'(rf_a3), 64'd4);
    check_eq("busy10_pend", 64'(busy), 64'h400);
    step();
    check_eq("n2_we",  64'(rf_we), 64'd1);
    check_eq("n2_a3",  64'(rf_a3), 64'd10);
    check_eq("n2_wd3", 64'(rf_wd3), 64'hAA);
    check_eq("busy10_clr", 64'(busy), 64'd0);
    step();

    // 5: writes to x0 are swallowed; x0 never becomes busy
    issue_ld = 1'b1; issue_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h6666;
    check_eq("x0_rdy", 64'({alu_ready, mem_ready}), 64'd3);
    step();
    issue_ld = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    check_eq("x0_busy", 64'(busy), 64'd0);
    check_eq("x0_we_alu", 64'(rf_we), 64'd0);
    step();
    check_eq("x0_we_ld", 64'(rf_we), 64'd0);
    step();
    check_eq("x0_we_idle", 64'(rf_we), 64'd0);

    // 6: reset with two loads buffered drops them
    issue_ld = 1'b1; issue_rd = 5'd7;
    step();
    issue_rd = 5'd8;
    step();
    issue_ld = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB1;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
    push_exp(5'd11, 32'hB1);
    step();
    alu_rd = 5'd12; alu_data = 32'hB2;
    mem_rd = 5'd8; mem_data = 32'h78;
    push_exp(5'd12, 32'hB2);
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check_eq("pre_rst_busy", 64'(busy), 64'h180);
    check_eq("pre_rst_full", 64'(mem_ready), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_we",   64'(rf_we), 64'd0);
    check_eq("mid_rst_a3",   64'(rf_a3), 64'd0);
    check_eq("mid_rst_wd3",  64'(rf_wd3), 64'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post_rst_we", 64'(rf_we), 64'd0);
    end
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    check_eq("post_rst_rdy",  64'({alu_ready, mem_ready}), 64'd3);
    check_eq("exp_q_empty",   64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
